// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-packed-BCD converter (shift-add-3 / double dabble).
// Accepts an unsigned binary word on a valid/ready handshake, iterates one input
// bit per clock, and publishes an 8-digit packed BCD result that feeds the
// seven-segment display. The previous result stays on bcd_out until the next
// conversion completes. Inputs above 99_999_999 saturate to all nines.
//
// Ports:
//   clk_in         system clock, all logic on posedge
//   rst_n_in       asynchronous active-low reset
//   bin_in         unsigned binary input, sampled only on the handshake
//   valid_in       bin_in valid
//   ready_out      converter idle, can accept
//   bcd_out        packed BCD result, [3:0] = ones digit
//   bcd_valid_out  one-cycle pulse when bcd_out has just been updated
//   overflow_out   last result saturated
//   busy_out       conversion in progress (inverse of ready_out)
module bin_to_bcd_display #(
  parameter int unsigned IN_WIDTH = 27
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [31:0]         bcd_out,
  output logic                bcd_valid_out,
  output logic                overflow_out,
  output logic                busy_out
);

  if (IN_WIDTH < 1 || IN_WIDTH > 27) begin : g_bad_width
    $error("bin_to_bcd_display: IN_WIDTH must be in 1..27");
  end

  localparam int unsigned ScratchW = 32 + IN_WIDTH;
  localparam logic [4:0]  LastCnt  = 5'(IN_WIDTH - 1);
  localparam logic [31:0] MaxDec   = 32'd99_999_999;

  typedef enum logic {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [ScratchW-1:0] scratch_q, scratch_corr, scratch_shift;
  logic [4:0]          cnt_q;
  logic                ovf_q;
  logic [31:0]         bcd_q;
  logic                bcd_valid_q;
  logic                overflow_q;

  logic accept;
  logic last_shift;
  logic in_ovf;

  assign accept     = valid_in && (state_q == StIdle);
  assign last_shift = (state_q == StShift) && (cnt_q == LastCnt);
  // Zero-extend to 32 bits so the compare is width-safe for every IN_WIDTH.
  assign in_ovf     = {{(32 - IN_WIDTH){1'b0}}, bin_in} > MaxDec;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (last_shift) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    ready_out = 1'b0;
    busy_out  = 1'b0;
    unique case (state_q)
      StIdle:  ready_out = 1'b1;
      StShift: busy_out  = 1'b1;
      default: ready_out = 1'b1;
    endcase
  end

  // Add-3 correction on all BCD nibbles in parallel, using pre-shift values,
  // then shift the whole {bcd, bin} scratch left by one.
  always_comb begin
    scratch_corr = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (scratch_q[IN_WIDTH + 4*i +: 4] >= 4'd5) begin
        scratch_corr[IN_WIDTH + 4*i +: 4] = scratch_q[IN_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    scratch_shift = {scratch_corr[ScratchW-2:0], 1'b0};
  end

  // Datapath and published result
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bcd_valid_q <= last_shift;
      if (accept) begin
        scratch_q <= {32'b0, bin_in};
        ovf_q     <= in_ovf;
        cnt_q     <= '0;
      end else if (state_q == StShift) begin
        scratch_q <= scratch_shift;
        cnt_q     <= cnt_q + 5'd1;
      end
      // Result registers move only at completion so the display never sees
      // partial data.
      if (last_shift) begin
        bcd_q      <= ovf_q ? 32'h9999_9999 : scratch_shift[ScratchW-1:IN_WIDTH];
        overflow_q <= ovf_q;
      end
    end
  end

  assign bcd_out       = bcd_q;
  assign bcd_valid_out = bcd_valid_q;
  assign overflow_out  = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Self-checking bench for bin_to_bcd_display. Two instances: IN_WIDTH=27 and
// IN_WIDTH=8. Expected results come from a decimal-digit reference model.
module tb_bin_to_bcd_display;

  logic        clk;
  logic        rst_n;

  logic [26:0] bin_a;
  logic        valid_a, ready_a, bv_a, ovf_a, busy_a;
  logic [31:0] bcd_a;

  logic [7:0]  bin_b;
  logic        valid_b, ready_b, bv_b, ovf_b, busy_b;
  logic [31:0] bcd_b;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  bit          cur_sel = 1'b0;
  logic        obs_ready, obs_bv, obs_ovf, obs_busy;
  logic [31:0] obs_bcd;

  assign obs_ready = cur_sel ? ready_b : ready_a;
  assign obs_bv    = cur_sel ? bv_b    : bv_a;
  assign obs_ovf   = cur_sel ? ovf_b   : ovf_a;
  assign obs_busy  = cur_sel ? busy_b  : busy_a;
  assign obs_bcd   = cur_sel ? bcd_b   : bcd_a;

  bin_to_bcd_display #(.IN_WIDTH(27)) dut_a (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .bin_in        (bin_a),
    .valid_in      (valid_a),
    .ready_out     (ready_a),
    .bcd_out       (bcd_a),
    .bcd_valid_out (bv_a),
    .overflow_out  (ovf_a),
    .busy_out      (busy_a)
  );

  bin_to_bcd_display #(.IN_WIDTH(8)) dut_b (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .bin_in        (bin_b),
    .valid_in      (valid_b),
    .ready_out     (ready_b),
    .bcd_out       (bcd_b),
    .bcd_valid_out (bv_b),
    .overflow_out  (ovf_b),
    .busy_out      (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal digits of v, one per nibble; saturate above eight digits.
  function automatic logic [31:0] ref_bcd(input longint v);
    logic [31:0] r;
    longint t;
    if (v > 64'd99_999_999) return 32'h9999_9999;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bin(input bit sel, input longint v);
    if (sel) bin_b = 8'(v);
    else     bin_a = 27'(v);
  endtask

  task automatic drive_valid(input bit sel, input logic v);
    if (sel) valid_b = v;
    else     valid_a = v;
  endtask

  // One full conversion with latency, result, hold and pulse-width checks.
  task automatic convert(input bit sel, input longint v, input string tag);
    int          n;
    int          w;
    bit          seen;
    logic [31:0] exp;
    w       = sel ? 8 : 27;
    cur_sel = sel;
    exp     = ref_bcd(v);
    n = 0;
    while (!obs_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(obs_ready), 32'd1);
    drive_bin(sel, v);
    drive_valid(sel, 1'b1);
    @(posedge clk); #1;
    drive_valid(sel, 1'b0);
    check({tag, "_busy"}, {30'd0, obs_busy, obs_ready}, 32'd2);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      drive_bin(sel, longint'($urandom));
      @(posedge clk); #1; n++;
      seen = obs_bv;
    end
    check({tag, "_latency"}, 32'(n), 32'(w));
    check({tag, "_bcd"}, obs_bcd, exp);
    check({tag, "_ovf"}, 32'(obs_ovf), 32'(v > 64'd99_999_999));
    check({tag, "_idle"}, 32'(obs_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check({tag, "_pulse"}, 32'(obs_bv), 32'd0);
    check({tag, "_hold"}, obs_bcd, exp);
  endtask

  initial begin
    int  n_acc;
    int  m;
    bit  got5;
    bit  prev_ready;
    bit  seen;

    rst_n   = 1'b1;
    bin_a   = '0;
    valid_a = 1'b0;
    bin_b   = '0;
    valid_b = 1'b0;

    // Reset asserted mid-clock takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_bcd", bcd_a, 32'd0);
    check("rst_bv", 32'(bv_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_b_bcd", bcd_b, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    convert(1'b0, 12_345_678, "dec12345678");
    convert(1'b0, 0, "zero");
    convert(1'b0, 99_999_999, "max_dec");
    convert(1'b0, 100_000_000, "ovf_first");
    convert(1'b0, 134_217_727, "ovf_max");
    convert(1'b1, 255, "w8_255");
    convert(1'b1, 0, "w8_zero");

    // valid_in held high: 5 then 42, bin_in toggling during SHIFT.
    cur_sel = 1'b0;
    bin_a   = 27'd5;
    valid_a = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_busy", 32'(ready_a), 32'd0);
    n_acc      = 0;
    got5       = 1'b0;
    prev_ready = 1'b0;
    for (int n = 1; n <= 40 && n_acc == 0; n++) begin
      bin_a = (n >= 26) ? 27'd42 : 27'($urandom);
      @(posedge clk); #1;
      if (bv_a) begin
        check("b2b_first_bcd", bcd_a, 32'h0000_0005);
        got5 = 1'b1;
      end
      if (prev_ready && !ready_a) n_acc = n;
      prev_ready = ready_a;
    end
    check("b2b_first_done", 32'(got5), 32'd1);
    check("b2b_accept_gap", 32'(n_acc), 32'd28);
    valid_a = 1'b0;
    m    = 0;
    seen = 1'b0;
    while (!seen && m < 60) begin
      bin_a = 27'($urandom);
      @(posedge clk); #1; m++;
      seen = bv_a;
    end
    check("b2b_second_latency", 32'(m), 32'd27);
    check("b2b_second_bcd", bcd_a, 32'h0000_0042);

    // Reset pulse at SHIFT cycle 10 aborts the conversion.
    bin_a   = 27'd134_217_727;
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    check("abort_ready_now", 32'(ready_a), 32'd1);
    check("abort_bcd_now", bcd_a, 32'd0);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bv_a) seen = 1'b1;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);
    check("abort_bcd", bcd_a, 32'd0);
    check("abort_ready", 32'(ready_a), 32'd1);
    check("abort_ovf", 32'(ovf_a), 32'd0);

    // Randomized sweeps against the reference model.
    for (int i = 0; i < 12; i++) begin
      convert(1'b0, longint'($urandom_range(134_217_727, 0)), "rand27");
    end
    for (int i = 0; i < 6; i++) begin
      convert(1'b0, longint'($urandom_range(99_999, 0)), "rand27_small");
    end
    for (int i = 0; i < 12; i++) begin
      convert(1'b1, longint'($urandom_range(255, 0)), "rand8");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
